sponge_absorb: RTL and testbench

- Absorb stage of the sponge hash datapath. It sits directly upstream of squeez.
- Accepts the message as 32-bit rate words over a valid/ready handshake and applies 10* byte padding.
- XORs each word into the rate, then drives the external permutation core once per block using the start/Gdone style handshake.
- When the final padded block has been permuted, it presents r and c to squeez, holds them until squeezDone, then returns to idle.

---
 rtl/sponge_pkg.sv | 36 +++
 rtl/sponge_absorb_pad.sv | 35 +++
 rtl/sponge_absorb.sv | 153 +++++++++++++++
 tb/tb_sponge_absorb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sponge_pkg.sv
// Shared definitions for the sponge absorb datapath.
// Contents: FSM state encoding, default rate/capacity widths, the pad byte,
// and pad_word(), which applies 10* byte padding to a left-aligned word.
package sponge_pkg;

   localparam int RWIDTH_DEF = 32;
   localparam int CWIDTH_DEF = 320;
   // Widest rate word pad_word() can handle; narrower words are left-aligned into it.
   localparam int RW_MAX     = 256;

   localparam logic [7:0] PAD_BYTE = 8'h80;

   typedef enum logic [2:0] {
      IDLE,
      ABSORB,
      PERM_REQ,
      PERM_WAIT,
      DONE
   } state_e;

   // Byte 0 is the most significant byte. Bytes below nbytes are kept, byte
   // nbytes becomes PAD_BYTE, everything after is zero.
   function automatic logic [RW_MAX-1:0] pad_word(input logic [RW_MAX-1:0] data,
                                                  input int nbytes);
      logic [RW_MAX-1:0] res;
      res = '0;
      for (int i = 0; i < RW_MAX/8; i++) begin
         if (i < nbytes)
            res[RW_MAX-1-8*i -: 8] = data[RW_MAX-1-8*i -: 8];
         else if (i == nbytes)
            res[RW_MAX-1-8*i -: 8] = PAD_BYTE;
      end
      return res;
   endfunction

endpackage

// File: rtl/sponge_absorb_pad.sv
// absorb_pad: padding of the final message word.
// Ports:
//   data_i    - message word, byte 0 in the MSBs
//   nbytes_i  - valid byte count (values above RWIDTH/8 are clamped)
//   padded_o  - word with unused bytes cleared and PAD_BYTE appended
//   full_o    - the word is completely full, so the pad must go in an extra block
module absorb_pad
   import sponge_pkg::*;
#(
   parameter int RWIDTH = RWIDTH_DEF,
   parameter int NBW    = $clog2(RWIDTH/8) + 1
) (
   input  logic [RWIDTH-1:0] data_i,
   input  logic [NBW-1:0]    nbytes_i,
   output logic [RWIDTH-1:0] padded_o,
   output logic              full_o
);

   localparam int RBYTES = RWIDTH / 8;

   int                nb;
   logic [RW_MAX-1:0] ext;

   always_comb begin
      nb = int'(nbytes_i);
      if (nb > RBYTES)
         nb = RBYTES;
      full_o = (nb == RBYTES);
      // Left-align into the wide word so byte 0 lines up with pad_word's byte 0.
      // A full word places the pad byte just below the slice and so drops it.
      ext      = RW_MAX'(data_i) << (RW_MAX - RWIDTH);
      padded_o = RWIDTH'(pad_word(ext, nb) >> (RW_MAX - RWIDTH));
   end

endmodule

// File: rtl/sponge_absorb.sv
// sponge_absorb: absorb stage of the sponge hash.
// Takes message words over msg_valid/msg_ready, pads the last one (10* byte
// padding), XORs each block into the rate and runs the external permutation
// via perm_start/Gdone. After the final block it holds r/c with absorbDone
// high until squeezDone.
// Ports:
//   clk, reset (async, active-low), start
//   msg_data/msg_bytes/msg_last/msg_valid -> msg_ready
//   perm_start, perm_out -> permutation core; perm_in, Gdone <- core
//   r, c, rounds, absorbDone -> squeez; squeezDone <- squeez
module sponge_absorb
   import sponge_pkg::*;
#(
   parameter int                         CWIDTH      = CWIDTH_DEF,
   parameter int                         RWIDTH      = RWIDTH_DEF,
   parameter int                         ROUND_COUNT = 10,
   parameter logic [CWIDTH+RWIDTH-1:0]   IV          = '0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [RWIDTH-1:0]                 msg_data,
   input  logic [$clog2(RWIDTH/8):0]         msg_bytes,
   input  logic                              msg_last,
   input  logic                              msg_valid,
   output logic                              msg_ready,
   output logic                              perm_start,
   output logic [RWIDTH+CWIDTH-1:0]          perm_out,
   input  logic [RWIDTH+CWIDTH-1:0]          perm_in,
   input  logic                              Gdone,
   output logic [RWIDTH-1:0]                 r,
   output logic [CWIDTH-1:0]                 c,
   output logic [ROUND_COUNT-1:0]            rounds,
   output logic                              absorbDone,
   input  logic                              squeezDone
);

   localparam logic [RWIDTH-1:0] PAD_MSB = RWIDTH'(PAD_BYTE) << (RWIDTH - 8);

   state_e                 state_q, state_d;
   logic [RWIDTH-1:0]      r_q, r_d;
   logic [CWIDTH-1:0]      c_q, c_d;
   logic [ROUND_COUNT-1:0] rounds_q, rounds_d;
   logic                   pad_pending_q, pad_pending_d;
   logic                   final_flag_q, final_flag_d;
   logic                   perm_start_q, perm_start_d;
   logic                   absorb_done_q, absorb_done_d;

   logic [RWIDTH-1:0]      padded;
   logic                   full;

   absorb_pad #(.RWIDTH(RWIDTH)) u_pad (
      .data_i   (msg_data),
      .nbytes_i (msg_bytes),
      .padded_o (padded),
      .full_o   (full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         r_q           <= '0;
         c_q           <= '0;
         rounds_q      <= '0;
         pad_pending_q <= 1'b0;
         final_flag_q  <= 1'b0;
         perm_start_q  <= 1'b0;
         absorb_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         r_q           <= r_d;
         c_q           <= c_d;
         rounds_q      <= rounds_d;
         pad_pending_q <= pad_pending_d;
         final_flag_q  <= final_flag_d;
         perm_start_q  <= perm_start_d;
         absorb_done_q <= absorb_done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      r_d           = r_q;
      c_d           = c_q;
      rounds_d      = rounds_q;
      pad_pending_d = pad_pending_q;
      final_flag_d  = final_flag_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               {r_d, c_d}    = IV;
               rounds_d      = '0;
               pad_pending_d = 1'b0;
               final_flag_d  = 1'b0;
               state_d       = ABSORB;
            end
         end
         ABSORB: begin
            if (msg_valid) begin
               if (msg_last) begin
                  // A full last word has no room for the pad byte; it goes
                  // into a separate block after this permutation.
                  r_d           = r_q ^ padded;
                  final_flag_d  = 1'b1;
                  pad_pending_d = full;
               end else begin
                  r_d = r_q ^ msg_data;
               end
               state_d = PERM_REQ;
            end
         end
         PERM_REQ: begin
            state_d = PERM_WAIT;
         end
         PERM_WAIT: begin
            if (Gdone) begin
               {r_d, c_d} = perm_in;
               if (rounds_q != '1)
                  rounds_d = rounds_q + 1'b1;
               if (pad_pending_q) begin
                  r_d           = perm_in[RWIDTH+CWIDTH-1 -: RWIDTH] ^ PAD_MSB;
                  pad_pending_d = 1'b0;
                  state_d       = PERM_REQ;
               end else if (final_flag_q) begin
                  state_d = DONE;
               end else begin
                  state_d = ABSORB;
               end
            end
         end
         DONE: begin
            if (squeezDone)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Registered outputs are decoded from the next state so they line up
      // with the state they describe.
      perm_start_d  = (state_d == PERM_REQ);
      absorb_done_d = (state_d == DONE);
   end

   assign msg_ready  = (state_q == ABSORB);
   assign perm_out   = {r_q, c_q};
   assign perm_start = perm_start_q;
   assign absorbDone = absorb_done_q;
   assign r          = r_q;
   assign c          = c_q;
   assign rounds     = rounds_q;

endmodule

// File: tb/tb_sponge_absorb.sv
module tb_sponge_absorb;

   localparam int RW = 32;
   localparam int CW = 320;
   localparam int SW = RW + CW;
   localparam int RC = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [RW-1:0] msg_data = '0;
   logic [2:0]    msg_bytes = '0;
   logic          msg_last = 1'b0;
   logic          msg_valid = 1'b0;
   logic          msg_ready;
   logic          perm_start;
   logic [SW-1:0] perm_out;
   logic [SW-1:0] perm_in = '0;
   logic          Gdone = 1'b0;
   logic [RW-1:0] r;
   logic [CW-1:0] c;
   logic [RC-1:0] rounds;
   logic          absorbDone;
   logic          squeezDone = 1'b0;

   sponge_absorb #(.CWIDTH(CW), .RWIDTH(RW), .ROUND_COUNT(RC)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .msg_data   (msg_data),
      .msg_bytes  (msg_bytes),
      .msg_last   (msg_last),
      .msg_valid  (msg_valid),
      .msg_ready  (msg_ready),
      .perm_start (perm_start),
      .perm_out   (perm_out),
      .perm_in    (perm_in),
      .Gdone      (Gdone),
      .r          (r),
      .c          (c),
      .rounds     (rounds),
      .absorbDone (absorbDone),
      .squeezDone (squeezDone)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] rotl1(input logic [SW-1:0] x);
      return {x[SW-2:0], x[SW-1]};
   endfunction

   // Scoreboard: expected perm_out values, pushed when words are driven.
   logic [SW-1:0] exp_q[$];
   logic [SW-1:0] st_m = '0;
   int            exp_rounds = 0;

   // Permutation stub: 3-cycle latency, returns {r,c} rotated left by 1.
   int            pend = 0;
   logic [SW-1:0] held = '0;
   int            gdone_cyc = -10;
   int            acc_cyc = -1;
   bit            acc_valid = 1'b0;

   always @(negedge clk) begin
      Gdone = 1'b0;
      if (!reset) begin
         pend = 0;
      end else begin
         if (pend > 0 || perm_start)
            chk("ready_low_while_busy", SW'(msg_ready), SW'(0));
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               chk("perm_out_stable", perm_out, held);
               perm_in   = rotl1(held);
               Gdone     = 1'b1;
               gdone_cyc = cyc;
            end
         end
         if (perm_start) begin
            chk("perm_expected", SW'(exp_q.size() > 0), SW'(1));
            if (exp_q.size() > 0)
               chk("perm_out", perm_out, exp_q.pop_front());
            if (acc_valid) begin
               chk("accept_to_start", SW'(cyc), SW'(acc_cyc));
               acc_valid = 1'b0;
            end
            held = perm_out;
            pend = 2;
         end
      end
   end

   task automatic push_block();
      exp_q.push_back(st_m);
      st_m = rotl1(st_m);
      exp_rounds++;
   endtask

   task automatic start_hash();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      st_m = '0;
      exp_rounds = 0;
      chk("ready_after_start", SW'(msg_ready), SW'(1));
   endtask

   // Called on a negedge; returns on the negedge after the word is accepted,
   // leaving msg_valid high.
   task automatic send_word(input logic [RW-1:0] data, input logic last, input logic [2:0] bytes);
      int            n;
      logic [RW-1:0] pw;
      bit            got;
      n = (bytes > 3'd4) ? 4 : int'(bytes);
      if (!last) begin
         st_m[SW-1 -: RW] ^= data;
         push_block();
      end else if (n < 4) begin
         pw = '0;
         for (int i = 0; i < 4; i++) begin
            if (i < n)       pw[31-8*i -: 8] = data[31-8*i -: 8];
            else if (i == n) pw[31-8*i -: 8] = 8'h80;
         end
         st_m[SW-1 -: RW] ^= pw;
         push_block();
      end else begin
         st_m[SW-1 -: RW] ^= data;
         push_block();
         st_m[SW-1 -: RW] ^= 32'h8000_0000;
         push_block();
      end
      msg_data  = data;
      msg_last  = last;
      msg_bytes = bytes;
      msg_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (msg_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("accept_within_budget", SW'(got), SW'(1));
      acc_cyc   = cyc + 1;
      acc_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_done();
      bit seen;
      msg_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (absorbDone) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("done_within_budget", SW'(seen), SW'(1));
      chk("gdone_to_done", SW'(cyc), SW'(gdone_cyc + 1));
      chk("final_r", SW'(r), SW'(st_m[SW-1 -: RW]));
      chk("final_c", SW'(c), SW'(st_m[CW-1:0]));
      chk("rounds", SW'(rounds), SW'(exp_rounds));
      chk("scoreboard_empty", SW'(exp_q.size()), SW'(0));
   endtask

   task automatic release_state();
      squeezDone = 1'b1;
      @(negedge clk);
      squeezDone = 1'b0;
      chk("done_clears", SW'(absorbDone), SW'(0));
      @(negedge clk);
   endtask

   initial begin
      logic [RW-1:0] r_snap;
      logic [CW-1:0] c_snap;
      bit            back;

      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_r", SW'(r), SW'(0));
      chk("rst_c", SW'(c), SW'(0));
      chk("rst_rounds", SW'(rounds), SW'(0));
      chk("rst_ready", SW'(msg_ready), SW'(0));
      chk("rst_perm_start", SW'(perm_start), SW'(0));
      chk("rst_done", SW'(absorbDone), SW'(0));
      chk("rst_perm_out", perm_out, SW'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("idle_ready", SW'(msg_ready), SW'(0));

      // Short last word, then the squeez handoff.
      start_hash();
      send_word(32'h7965_7370, 1'b1, 3'd3);
      wait_done();
      r_snap = r;
      c_snap = c;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("hold_done", SW'(absorbDone), SW'(1));
         chk("hold_r", SW'(r), SW'(r_snap));
         chk("hold_c", SW'(c), SW'(c_snap));
      end
      squeezDone = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      squeezDone = 1'b0;
      start      = 1'b0;
      chk("handoff_done_low", SW'(absorbDone), SW'(0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("start_ignored_in_done", SW'(msg_ready), SW'(0));
      end

      // Full last word: the pad goes in a second block.
      start_hash();
      send_word(32'h7965_7370, 1'b1, 3'd4);
      wait_done();
      release_state();

      // Empty message; data bits must be masked off.
      start_hash();
      send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
      wait_done();
      release_state();

      // Three words back-to-back, short last word.
      start_hash();
      send_word(32'h0123_4567, 1'b0, 3'd0);
      send_word(32'h89AB_CDEF, 1'b0, 3'd0);
      send_word(32'hCAFE_F00D, 1'b1, 3'd2);
      wait_done();
      release_state();

      // Three words back-to-back, over-range byte count clamps to a full word.
      start_hash();
      send_word(32'h1357_9BDF, 1'b0, 3'd0);
      send_word(32'h2468_ACE0, 1'b0, 3'd0);
      send_word(32'hA5A5_5A5A, 1'b1, 3'd7);
      wait_done();
      release_state();

      // Reset in ABSORB after one permutation has dirtied the state.
      start_hash();
      send_word(32'h1122_3344, 1'b0, 3'd0);
      msg_valid = 1'b0;
      back = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (msg_ready) begin
            back = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("back_to_absorb", SW'(back), SW'(1));
      chk("state_dirty", SW'(r), SW'(st_m[SW-1 -: RW]));
      reset = 1'b0;
      #1;
      chk("mid_rst_r", SW'(r), SW'(0));
      chk("mid_rst_c", SW'(c), SW'(0));
      chk("mid_rst_rounds", SW'(rounds), SW'(0));
      chk("mid_rst_ready", SW'(msg_ready), SW'(0));
      chk("mid_rst_done", SW'(absorbDone), SW'(0));
      chk("mid_rst_perm_out", perm_out, SW'(0));
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("post_rst_idle", SW'(msg_ready), SW'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
